idu_exu_stage: RTL and testbench

- ID→EX pipeline register directly upstream of the ALU.
- Captures decoded instructions and resolves operand forwarding from the EX, MEM and WB stages.
- Detects load-use hazards, stalls decode and inserts a bubble when one occurs.
- Drives the ALU type, the two ALU operands and the EX-stage sideband from registered state, under a valid/ready handshake on both sides plus a flush.

---
 rtl/idu_exu_stage_if.sv | 65 ++++++
 rtl/idu_exu_stage.sv | 100 ++++++++++
 tb/tb_idu_exu_stage.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idu_exu_stage_if.sv
// Decode-side and EX-side bundle of the ID->EX pipeline register.
// The stage connects through the slave modport and the surrounding pipeline through master.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif

interface idu_exu_stage_if;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned AW = `ARGS_WIDTH;
  localparam int unsigned RW = 5;

  logic          i_flush;
  logic          i_id_valid;
  logic          o_id_ready;
  logic [AW-1:0] i_id_alu_type;
  logic [DW-1:0] i_id_pc;
  logic [DW-1:0] i_id_imm;
  logic          i_id_use_pc;
  logic          i_id_use_imm;
  logic [RW-1:0] i_id_rs1_addr;
  logic [RW-1:0] i_id_rs2_addr;
  logic [DW-1:0] i_id_rs1_data;
  logic [DW-1:0] i_id_rs2_data;
  logic [RW-1:0] i_id_rd_addr;
  logic          i_id_rd_wen;
  logic          i_id_is_load;
  logic [DW-1:0] i_ex_res;
  logic [RW-1:0] i_mem_rd_addr;
  logic          i_mem_rd_wen;
  logic [DW-1:0] i_mem_rd_data;
  logic [RW-1:0] i_wb_rd_addr;
  logic          i_wb_rd_wen;
  logic [DW-1:0] i_wb_rd_data;
  logic          o_ex_valid;
  logic          i_ex_ready;
  logic [AW-1:0] o_alu_type;
  logic [DW-1:0] o_alu_rs1_data;
  logic [DW-1:0] o_alu_rs2_data;
  logic [DW-1:0] o_ex_store_data;
  logic [DW-1:0] o_ex_pc;
  logic [RW-1:0] o_ex_rd_addr;
  logic          o_ex_rd_wen;
  logic          o_ex_is_load;

  modport slave (
    input  i_flush, i_id_valid, i_id_alu_type, i_id_pc, i_id_imm, i_id_use_pc, i_id_use_imm,
           i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_data, i_id_rs2_data, i_id_rd_addr,
           i_id_rd_wen, i_id_is_load, i_ex_res, i_mem_rd_addr, i_mem_rd_wen, i_mem_rd_data,
           i_wb_rd_addr, i_wb_rd_wen, i_wb_rd_data, i_ex_ready,
    output o_id_ready, o_ex_valid, o_alu_type, o_alu_rs1_data, o_alu_rs2_data,
           o_ex_store_data, o_ex_pc, o_ex_rd_addr, o_ex_rd_wen, o_ex_is_load
  );

  modport master (
    output i_flush, i_id_valid, i_id_alu_type, i_id_pc, i_id_imm, i_id_use_pc, i_id_use_imm,
           i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_data, i_id_rs2_data, i_id_rd_addr,
           i_id_rd_wen, i_id_is_load, i_ex_res, i_mem_rd_addr, i_mem_rd_wen, i_mem_rd_data,
           i_wb_rd_addr, i_wb_rd_wen, i_wb_rd_data, i_ex_ready,
    input  o_id_ready, o_ex_valid, o_alu_type, o_alu_rs1_data, o_alu_rs2_data,
           o_ex_store_data, o_ex_pc, o_ex_rd_addr, o_ex_rd_wen, o_ex_is_load
  );
endinterface

// File: rtl/idu_exu_stage.sv
// ID->EX pipeline register feeding the ALU: operand forwarding from EX/MEM/WB,
// load-use bubble insertion, valid/ready handshake on both sides and flush.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`DATA_WIDTH{1'b0}}
`endif

module idu_exu_stage (
  input logic            i_clk,
  input logic            i_rst_n,
  idu_exu_stage_if.slave bus
);
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned AW = `ARGS_WIDTH;
  localparam int unsigned RW = 5;

  logic          adv;
  logic          hazard;
  logic          ex_fwd_ok;
  logic [RW-1:0] rs_addr [2];
  logic [DW-1:0] rf_data [2];
  logic [DW-1:0] fwd     [2];

  assign rs_addr[0] = bus.i_id_rs1_addr;
  assign rs_addr[1] = bus.i_id_rs2_addr;
  assign rf_data[0] = bus.i_id_rs1_data;
  assign rf_data[1] = bus.i_id_rs2_data;

  assign adv = ~bus.o_ex_valid | bus.i_ex_ready;

  // Conservative load-use check: compares both sources even if PC/imm replace them.
  assign hazard = bus.i_id_valid & bus.o_ex_valid & bus.o_ex_is_load & bus.o_ex_rd_wen &
                  (bus.o_ex_rd_addr != RW'(0)) &
                  ((bus.o_ex_rd_addr == bus.i_id_rs1_addr) |
                   (bus.o_ex_rd_addr == bus.i_id_rs2_addr));

  assign bus.o_id_ready = adv & (~hazard | bus.i_flush);

  // A held load has no result yet, so only non-load EX results are forwardable.
  assign ex_fwd_ok = bus.o_ex_valid & bus.o_ex_rd_wen & ~bus.o_ex_is_load;

  // Forwarding mux, youngest producer wins; x0 always reads zero.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fwd[i] = rf_data[i];
      if (rs_addr[i] == RW'(0)) begin
        fwd[i] = `DATA_ZERO;
      end else if (ex_fwd_ok && bus.o_ex_rd_addr == rs_addr[i]) begin
        fwd[i] = bus.i_ex_res;
      end else if (bus.i_mem_rd_wen && bus.i_mem_rd_addr == rs_addr[i]) begin
        fwd[i] = bus.i_mem_rd_data;
      end else if (bus.i_wb_rd_wen && bus.i_wb_rd_addr == rs_addr[i]) begin
        fwd[i] = bus.i_wb_rd_data;
      end
    end
  end

  // Flush is honoured on every edge, even while EX back-pressures.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_ex_valid      <= 1'b0;
      bus.o_alu_type      <= AW'(0);
      bus.o_alu_rs1_data  <= `DATA_ZERO;
      bus.o_alu_rs2_data  <= `DATA_ZERO;
      bus.o_ex_store_data <= `DATA_ZERO;
      bus.o_ex_pc         <= `DATA_ZERO;
      bus.o_ex_rd_addr    <= RW'(0);
      bus.o_ex_rd_wen     <= 1'b0;
      bus.o_ex_is_load    <= 1'b0;
    end else if (bus.i_flush) begin
      bus.o_ex_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        bus.o_ex_valid   <= 1'b0;
        bus.o_ex_rd_wen  <= 1'b0;
        bus.o_ex_is_load <= 1'b0;
      end else begin
        bus.o_ex_valid <= bus.i_id_valid;
        if (bus.i_id_valid) begin
          bus.o_alu_type      <= bus.i_id_alu_type;
          bus.o_alu_rs1_data  <= bus.i_id_use_pc  ? bus.i_id_pc  : fwd[0];
          bus.o_alu_rs2_data  <= bus.i_id_use_imm ? bus.i_id_imm : fwd[1];
          bus.o_ex_store_data <= fwd[1];
          bus.o_ex_pc         <= bus.i_id_pc;
          bus.o_ex_rd_addr    <= bus.i_id_rd_addr;
          bus.o_ex_rd_wen     <= bus.i_id_rd_wen;
          bus.o_ex_is_load    <= bus.i_id_is_load;
        end else begin
          bus.o_ex_rd_wen  <= 1'b0;
          bus.o_ex_is_load <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_idu_exu_stage.sv
// Bench for idu_exu_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the held instruction.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 4
`endif
`ifndef ALU_TYPE_ADD
`define ALU_TYPE_ADD 4'd1
`endif
`ifndef ALU_TYPE_SUB
`define ALU_TYPE_SUB 4'd2
`endif

module tb_idu_exu_stage;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned AW = `ARGS_WIDTH;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] alu;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] store;
    logic [DW-1:0] pc;
    logic [4:0]    rd;
    logic          wen;
    logic          load;
  } held_t;

  logic  clk;
  logic  rst_n;
  int    checks = 0;
  int    errors = 0;
  held_t m;
  held_t mn;

  idu_exu_stage_if bus ();

  idu_exu_stage dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source value the instruction should see, by producer age.
  function automatic logic [DW-1:0] ref_fwd(input logic [4:0] rs, input logic [DW-1:0] rf);
    if (rs == 5'd0) return '0;
    if (m.valid && m.wen && !m.load && m.rd == rs) return bus.i_ex_res;
    if (bus.i_mem_rd_wen && bus.i_mem_rd_addr == rs) return bus.i_mem_rd_data;
    if (bus.i_wb_rd_wen && bus.i_wb_rd_addr == rs) return bus.i_wb_rd_data;
    return rf;
  endfunction

  function automatic logic ref_stall_load();
    return bus.i_id_valid && m.valid && m.load && m.wen && m.rd != 5'd0 &&
           (m.rd == bus.i_id_rs1_addr || m.rd == bus.i_id_rs2_addr);
  endfunction

  function automatic logic ref_ready();
    logic can_move;
    can_move = !m.valid || bus.i_ex_ready;
    return can_move && (!ref_stall_load() || bus.i_flush);
  endfunction

  function automatic held_t ref_next();
    held_t n;
    n = m;
    if (!rst_n) begin
      n = '0;
    end else if (bus.i_flush) begin
      n.valid = 1'b0;
    end else if (!m.valid || bus.i_ex_ready) begin
      if (ref_stall_load()) begin
        n.valid = 1'b0; n.wen = 1'b0; n.load = 1'b0;
      end else if (bus.i_id_valid) begin
        n.valid = 1'b1;
        n.alu   = bus.i_id_alu_type;
        n.op1   = bus.i_id_use_pc ? bus.i_id_pc : ref_fwd(bus.i_id_rs1_addr, bus.i_id_rs1_data);
        n.op2   = bus.i_id_use_imm ? bus.i_id_imm : ref_fwd(bus.i_id_rs2_addr, bus.i_id_rs2_data);
        n.store = ref_fwd(bus.i_id_rs2_addr, bus.i_id_rs2_data);
        n.pc    = bus.i_id_pc;
        n.rd    = bus.i_id_rd_addr;
        n.wen   = bus.i_id_rd_wen;
        n.load  = bus.i_id_is_load;
      end else begin
        n.valid = 1'b0; n.wen = 1'b0; n.load = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic step();
    mn = ref_next();
    @(posedge clk);
    #1;
    m = mn;
  endtask

  task automatic idle();
    rst_n = 1'b1;
    bus.i_flush = 1'b0; bus.i_id_valid = 1'b0; bus.i_id_alu_type = '0;
    bus.i_id_pc = '0; bus.i_id_imm = '0; bus.i_id_use_pc = 1'b0; bus.i_id_use_imm = 1'b0;
    bus.i_id_rs1_addr = '0; bus.i_id_rs2_addr = '0; bus.i_id_rs1_data = '0; bus.i_id_rs2_data = '0;
    bus.i_id_rd_addr = '0; bus.i_id_rd_wen = 1'b0; bus.i_id_is_load = 1'b0; bus.i_ex_res = '0;
    bus.i_mem_rd_addr = '0; bus.i_mem_rd_wen = 1'b0; bus.i_mem_rd_data = '0;
    bus.i_wb_rd_addr = '0; bus.i_wb_rd_wen = 1'b0; bus.i_wb_rd_data = '0; bus.i_ex_ready = 1'b1;
  endtask

  task automatic set_id(input logic [AW-1:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic wen, input logic load, input logic use_imm);
    bus.i_id_valid = 1'b1; bus.i_id_alu_type = alu; bus.i_id_rd_addr = rd;
    bus.i_id_rs1_addr = rs1; bus.i_id_rs2_addr = rs2; bus.i_id_rs1_data = d1; bus.i_id_rs2_data = d2;
    bus.i_id_rd_wen = wen; bus.i_id_is_load = load; bus.i_id_use_pc = 1'b0; bus.i_id_use_imm = use_imm;
    bus.i_id_pc = 32'h0000_0100; bus.i_id_imm = 32'h0000_0040;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; bus.i_flush = 1'b1;
    set_id(`ALU_TYPE_SUB, 5'd9, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0);
    step(); step();
    checks++; if (bus.o_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h exp=0", bus.o_ex_valid); end
    checks++; if (bus.o_alu_type !== '0) begin errors++; $display("FAIL reset_alu_type got=%h exp=0", bus.o_alu_type); end
    checks++; if (bus.o_alu_rs1_data !== '0) begin errors++; $display("FAIL reset_rs1 got=%h exp=0", bus.o_alu_rs1_data); end
    checks++; if (bus.o_alu_rs2_data !== '0) begin errors++; $display("FAIL reset_rs2 got=%h exp=0", bus.o_alu_rs2_data); end
    checks++; if (bus.o_ex_rd_addr !== '0 || bus.o_ex_rd_wen !== 1'b0 || bus.o_ex_is_load !== 1'b0)
      begin errors++; $display("FAIL reset_sideband got=%h/%b/%b exp=0/0/0", bus.o_ex_rd_addr, bus.o_ex_rd_wen, bus.o_ex_is_load); end
    idle();
  endtask

  task automatic test_add();
    idle();
    set_id(`ALU_TYPE_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.o_id_ready !== 1'b1) begin errors++; $display("FAIL add_ready got=%b exp=1", bus.o_id_ready); end
    step();
    checks++; if (bus.o_ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.o_ex_valid); end
    checks++; if (bus.o_alu_type !== `ALU_TYPE_ADD) begin errors++; $display("FAIL add_type got=%h exp=%h", bus.o_alu_type, `ALU_TYPE_ADD); end
    checks++; if (bus.o_alu_rs1_data !== 32'd5) begin errors++; $display("FAIL add_rs1 got=%h exp=5", bus.o_alu_rs1_data); end
    checks++; if (bus.o_alu_rs2_data !== 32'd7) begin errors++; $display("FAIL add_rs2 got=%h exp=7", bus.o_alu_rs2_data); end
    checks++; if (bus.o_ex_rd_addr !== 5'd3) begin errors++; $display("FAIL add_rd got=%h exp=3", bus.o_ex_rd_addr); end
    idle(); step();
  endtask

  task automatic test_back_to_back();
    idle();
    set_id(`ALU_TYPE_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    step();
    set_id(`ALU_TYPE_SUB, 5'd4, 5'd3, 5'd1, 32'd99, 32'd5, 1'b1, 1'b0, 1'b0);
    bus.i_ex_res = 32'd12;
    #1;
    checks++; if (bus.o_id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bus.o_id_ready); end
    step();
    checks++; if (bus.o_alu_rs1_data !== 32'd12) begin errors++; $display("FAIL b2b_ex_fwd got=%h exp=c", bus.o_alu_rs1_data); end
    checks++; if (bus.o_alu_rs2_data !== 32'd5) begin errors++; $display("FAIL b2b_rs2 got=%h exp=5", bus.o_alu_rs2_data); end
    checks++; if (bus.o_alu_type !== `ALU_TYPE_SUB || bus.o_ex_rd_addr !== 5'd4)
      begin errors++; $display("FAIL b2b_sub got=%h/%h exp=%h/4", bus.o_alu_type, bus.o_ex_rd_addr, `ALU_TYPE_SUB); end
    idle(); step();
  endtask

  task automatic test_load_use();
    idle();
    set_id(`ALU_TYPE_ADD, 5'd5, 5'd1, 5'd0, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1);
    step();
    set_id(`ALU_TYPE_ADD, 5'd6, 5'd5, 5'd0, 32'h1111, 32'h55, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.o_id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready got=%b exp=0", bus.o_id_ready); end
    step();
    checks++; if (bus.o_ex_valid !== 1'b0 || bus.o_ex_rd_wen !== 1'b0 || bus.o_ex_is_load !== 1'b0)
      begin errors++; $display("FAIL lu_bubble got=%b/%b/%b exp=0/0/0", bus.o_ex_valid, bus.o_ex_rd_wen, bus.o_ex_is_load); end
    bus.i_mem_rd_addr = 5'd5; bus.i_mem_rd_wen = 1'b1; bus.i_mem_rd_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.o_id_ready !== 1'b1) begin errors++; $display("FAIL lu_release_ready got=%b exp=1", bus.o_id_ready); end
    step();
    checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_rd_addr !== 5'd6)
      begin errors++; $display("FAIL lu_capture got=%b/%h exp=1/6", bus.o_ex_valid, bus.o_ex_rd_addr); end
    checks++; if (bus.o_alu_rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lu_mem_fwd got=%h exp=deadbeef", bus.o_alu_rs1_data); end
    checks++; if (bus.o_alu_rs2_data !== 32'h0) begin errors++; $display("FAIL lu_x0 got=%h exp=0", bus.o_alu_rs2_data); end
    idle(); step();
  endtask

  task automatic test_fwd_priority();
    idle();
    set_id(`ALU_TYPE_ADD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    set_id(`ALU_TYPE_SUB, 5'd0, 5'd7, 5'd0, 32'hAA, 32'h77, 1'b1, 1'b0, 1'b0);
    bus.i_ex_res = 32'd1;
    bus.i_mem_rd_addr = 5'd7; bus.i_mem_rd_wen = 1'b1; bus.i_mem_rd_data = 32'd2;
    bus.i_wb_rd_addr = 5'd7; bus.i_wb_rd_wen = 1'b1; bus.i_wb_rd_data = 32'd3;
    step();
    checks++; if (bus.o_alu_rs1_data !== 32'd1) begin errors++; $display("FAIL fwd_ex_first got=%h exp=1", bus.o_alu_rs1_data); end
    checks++; if (bus.o_ex_store_data !== 32'd0) begin errors++; $display("FAIL fwd_store_x0 got=%h exp=0", bus.o_ex_store_data); end
    // Held instruction now writes x0; every source targets x0.
    set_id(`ALU_TYPE_ADD, 5'd9, 5'd0, 5'd0, 32'h44, 32'h55, 1'b1, 1'b0, 1'b0);
    bus.i_ex_res = 32'h11;
    bus.i_mem_rd_addr = 5'd0; bus.i_mem_rd_data = 32'h22;
    bus.i_wb_rd_addr = 5'd0; bus.i_wb_rd_data = 32'h33;
    step();
    checks++; if (bus.o_alu_rs1_data !== 32'd0 || bus.o_alu_rs2_data !== 32'd0)
      begin errors++; $display("FAIL fwd_x0 got=%h/%h exp=0/0", bus.o_alu_rs1_data, bus.o_alu_rs2_data); end
    // Flush leaves a dead instruction still naming x7 as destination.
    idle();
    set_id(`ALU_TYPE_ADD, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    bus.i_id_valid = 1'b0; bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    set_id(`ALU_TYPE_ADD, 5'd8, 5'd7, 5'd2, 32'hAA, 32'h0, 1'b1, 1'b0, 1'b0);
    bus.i_ex_res = 32'd1;
    bus.i_mem_rd_addr = 5'd7; bus.i_mem_rd_wen = 1'b1; bus.i_mem_rd_data = 32'd2;
    bus.i_wb_rd_addr = 5'd7; bus.i_wb_rd_wen = 1'b1; bus.i_wb_rd_data = 32'd3;
    step();
    checks++; if (bus.o_alu_rs1_data !== 32'd2) begin errors++; $display("FAIL fwd_ex_invalid got=%h exp=2", bus.o_alu_rs1_data); end
    bus.i_mem_rd_wen = 1'b0;
    set_id(`ALU_TYPE_ADD, 5'd8, 5'd7, 5'd2, 32'hAA, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    checks++; if (bus.o_alu_rs1_data !== 32'd3 || bus.o_alu_rs2_data !== 32'h40)
      begin errors++; $display("FAIL fwd_wb_imm got=%h/%h exp=3/40", bus.o_alu_rs1_data, bus.o_alu_rs2_data); end
    idle(); step();
  endtask

  task automatic test_backpressure();
    idle();
    set_id(`ALU_TYPE_ADD, 5'd10, 5'd1, 5'd2, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0);
    step();
    bus.i_ex_ready = 1'b0;
    set_id(`ALU_TYPE_SUB, 5'd11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.o_id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, bus.o_id_ready); end
      step();
      checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_rd_addr !== 5'd10 || bus.o_alu_type !== `ALU_TYPE_ADD ||
                    bus.o_alu_rs1_data !== 32'h10 || bus.o_alu_rs2_data !== 32'h20)
        begin errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h/%h exp=1/a/10/20", c, bus.o_ex_valid,
                                 bus.o_ex_rd_addr, bus.o_alu_rs1_data, bus.o_alu_rs2_data); end
    end
    bus.i_ex_ready = 1'b1;
    #1;
    checks++; if (bus.o_id_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", bus.o_id_ready); end
    step();
    checks++; if (bus.o_ex_rd_addr !== 5'd11 || bus.o_alu_rs1_data !== 32'h30 || bus.o_alu_rs2_data !== 32'h40 ||
                  bus.o_alu_type !== `ALU_TYPE_SUB)
      begin errors++; $display("FAIL bp_next got=%h/%h/%h exp=b/30/40", bus.o_ex_rd_addr, bus.o_alu_rs1_data, bus.o_alu_rs2_data); end
    idle(); step();
  endtask

  task automatic test_flush_reset();
    idle();
    set_id(`ALU_TYPE_ADD, 5'd5, 5'd1, 5'd0, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1);
    step();
    set_id(`ALU_TYPE_ADD, 5'd6, 5'd5, 5'd0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    bus.i_flush = 1'b1;
    #1;
    checks++; if (bus.o_id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", bus.o_id_ready); end
    step();
    checks++; if (bus.o_ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.o_ex_valid); end
    idle();
    set_id(`ALU_TYPE_ADD, 5'd12, 5'd1, 5'd2, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    step();
    bus.i_ex_ready = 1'b0; bus.i_flush = 1'b1;
    #1;
    checks++; if (bus.o_id_ready !== 1'b0) begin errors++; $display("FAIL flush_stall_ready got=%b exp=0", bus.o_id_ready); end
    step();
    checks++; if (bus.o_ex_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid got=%b exp=0", bus.o_ex_valid); end
    idle();
    set_id(`ALU_TYPE_SUB, 5'd13, 5'd1, 5'd2, 32'h99, 32'h98, 1'b1, 1'b1, 1'b0);
    step();
    checks++; if (bus.o_ex_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", bus.o_ex_valid); end
    rst_n = 1'b0;
    step();
    checks++; if (bus.o_ex_valid !== 1'b0 || bus.o_alu_type !== '0 || bus.o_alu_rs1_data !== '0 ||
                  bus.o_alu_rs2_data !== '0 || bus.o_ex_store_data !== '0 || bus.o_ex_pc !== '0 ||
                  bus.o_ex_rd_addr !== '0 || bus.o_ex_rd_wen !== 1'b0 || bus.o_ex_is_load !== 1'b0)
      begin errors++; $display("FAIL midrst_zero got=%b/%h/%h/%h/%h exp=all zero", bus.o_ex_valid, bus.o_alu_type,
                               bus.o_alu_rs1_data, bus.o_alu_rs2_data, bus.o_ex_rd_addr); end
    idle(); step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
      bus.i_id_valid = 1'($urandom);
      bus.i_ex_ready = ($urandom_range(0, 3) != 0);
      bus.i_id_alu_type = AW'($urandom);
      bus.i_id_pc = $urandom; bus.i_id_imm = $urandom;
      bus.i_id_use_pc = 1'($urandom); bus.i_id_use_imm = 1'($urandom);
      bus.i_id_rs1_addr = 5'($urandom_range(0, 3)); bus.i_id_rs2_addr = 5'($urandom_range(0, 3));
      bus.i_id_rs1_data = $urandom; bus.i_id_rs2_data = $urandom;
      bus.i_id_rd_addr = 5'($urandom_range(0, 3));
      bus.i_id_is_load = 1'($urandom);
      bus.i_id_rd_wen = bus.i_id_is_load | 1'($urandom);
      bus.i_ex_res = $urandom;
      bus.i_mem_rd_addr = 5'($urandom_range(0, 3)); bus.i_mem_rd_wen = 1'($urandom); bus.i_mem_rd_data = $urandom;
      bus.i_wb_rd_addr = 5'($urandom_range(0, 3)); bus.i_wb_rd_wen = 1'($urandom); bus.i_wb_rd_data = $urandom;
      #1;
      checks++; if (rst_n && bus.o_id_ready !== ref_ready())
        begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.o_id_ready, ref_ready()); end
      step();
      checks++; if (bus.o_ex_valid !== m.valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.o_ex_valid, m.valid); end
      checks++; if (bus.o_alu_type !== m.alu) begin errors++; $display("FAIL rnd_alu n=%0d got=%h exp=%h", n, bus.o_alu_type, m.alu); end
      checks++; if (bus.o_alu_rs1_data !== m.op1) begin errors++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, bus.o_alu_rs1_data, m.op1); end
      checks++; if (bus.o_alu_rs2_data !== m.op2) begin errors++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, bus.o_alu_rs2_data, m.op2); end
      checks++; if (bus.o_ex_store_data !== m.store) begin errors++; $display("FAIL rnd_store n=%0d got=%h exp=%h", n, bus.o_ex_store_data, m.store); end
      checks++; if (bus.o_ex_pc !== m.pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, bus.o_ex_pc, m.pc); end
      checks++; if (bus.o_ex_rd_addr !== m.rd || bus.o_ex_rd_wen !== m.wen || bus.o_ex_is_load !== m.load)
        begin errors++; $display("FAIL rnd_side n=%0d got=%h/%b/%b exp=%h/%b/%b", n, bus.o_ex_rd_addr,
                                 bus.o_ex_rd_wen, bus.o_ex_is_load, m.rd, m.wen, m.load); end
    end
    idle(); step();
  endtask

  initial begin
    m = '0;
    idle();
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_fwd_priority();
    test_backpressure();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
